// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Owns the DIV occupancy counter and defers exceptions until MEM is idle.
module pipeline_ctrl #(
  parameter int          DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_req,
  input  logic        div_start_i,
  input  logic        mem_stall_req,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_type_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        div_busy_o,
  output logic        div_done_o
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          pending_q, pending_d;
  logic [31:0]   pend_type_q, pend_type_d;

  logic        take;
  logic [31:0] type_sel;

  // Once latched, the pending exception wins over any newer one.
  assign take     = (exc_valid_i | pending_q) & ~mem_stall_req;
  assign type_sel = pending_q ? pend_type_q : exc_type_i;

  always_comb begin
    flush_o    = take;
    new_pc_o   = 32'd0;
    stall_o    = 6'b000000;
    div_busy_o = (state_q == ST_DIV_WAIT);
    div_done_o = (state_q == ST_DIV_WAIT) && (counter_q == CW'(1)) && !take;
    if (take) begin
      new_pc_o = type_sel[12] ? epc_i : EXC_VECTOR;
    end else if (state_q != ST_FLUSH) begin
      if (mem_stall_req) begin
        stall_o = 6'b011111;
      end else if ((state_q == ST_DIV_WAIT) && (counter_q > CW'(1))) begin
        stall_o = 6'b001111;
      end else if (id_stall_req) begin
        stall_o = 6'b000111;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    pending_d   = pending_q;
    pend_type_d = pend_type_q;
    if (take) begin
      state_d   = ST_FLUSH;
      counter_d = '0;
      pending_d = 1'b0;
    end else begin
      if (exc_valid_i && !pending_q) begin
        pending_d   = 1'b1;
        pend_type_d = exc_type_i;
      end
      case (state_q)
        ST_RUN: begin
          if (div_start_i) begin
            state_d   = ST_DIV_WAIT;
            counter_d = CW'(DIV_CYCLES);
          end
        end
        ST_DIV_WAIT: begin
          // Counts through MEM stalls so the divider's fixed latency holds.
          counter_d = counter_q - CW'(1);
          if (counter_q == CW'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      counter_q   <= '0;
      pending_q   <= 1'b0;
      pend_type_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      pending_q   <= pending_d;
      pend_type_q <= pend_type_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - vector table plus randomized model check of pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int          DIVC = 4;
  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] EPC  = 32'h80001234;

  logic        clk = 1'b0;
  logic        rst, id_stall_req, div_start_i, mem_stall_req, exc_valid_i;
  logic [31:0] exc_type_i, epc_i;
  logic [5:0]  stall_o;
  logic        flush_o, div_busy_o, div_done_o;
  logic [31:0] new_pc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(DIVC), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .id_stall_req(id_stall_req), .div_start_i(div_start_i),
    .mem_stall_req(mem_stall_req), .exc_valid_i(exc_valid_i), .exc_type_i(exc_type_i),
    .epc_i(epc_i), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .div_busy_o(div_busy_o), .div_done_o(div_done_o)
  );

  typedef struct {
    logic        chk;
    logic        rst, id, div, mem, exc;
    logic [31:0] typ;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic chk, logic r, logic id, logic dv, logic mem, logic exc,
                              logic [31:0] typ, logic [5:0] st, logic fl, logic [31:0] pc,
                              logic busy, logic done);
    vec_t v;
    v.chk = chk; v.rst = r; v.id = id; v.div = dv; v.mem = mem; v.exc = exc; v.typ = typ;
    v.e_stall = st; v.e_flush = fl; v.e_pc = pc; v.e_busy = busy; v.e_done = done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] st, input logic fl,
                           input logic [31:0] pc, input logic busy, input logic done);
    check({tag, " stall"}, {26'd0, stall_o}, {26'd0, st});
    check({tag, " flush"}, {31'd0, flush_o}, {31'd0, fl});
    check({tag, " new_pc"}, new_pc_o, pc);
    check({tag, " busy"}, {31'd0, div_busy_o}, {31'd0, busy});
    check({tag, " done"}, {31'd0, div_done_o}, {31'd0, done});
  endtask

  // Model state: DIV cycles left including the current one, bubble pending, deferred exception.
  int          m_left;
  bit          m_bubble, m_pend;
  logic [31:0] m_ptype;

  initial begin
    rst = 1'b1; id_stall_req = 0; div_start_i = 0; mem_stall_req = 0;
    exc_valid_i = 0; exc_type_i = 0; epc_i = EPC;

    vecs.push_back(mk(0,1,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0)); // reset state
    vecs.push_back(mk(1,0,1,0,0,0,0,      6'h07,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,      6'h00,0,0,  0,0)); // DIV issue
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h0F,0,0,  1,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,      6'h0F,0,0,  1,0)); // start ignored while busy
    vecs.push_back(mk(1,0,1,0,0,0,0,      6'h0F,0,0,  1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  1,1)); // done
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,1,32'h400,6'h00,1,VEC,0,0)); // exception
    vecs.push_back(mk(1,0,1,1,0,0,0,      6'h00,0,0,  0,0)); // bubble ignores id/div
    vecs.push_back(mk(1,0,1,0,0,0,0,      6'h07,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,1,1,32'h1000,6'h1F,0,0, 0,0)); // ERET deferred
    vecs.push_back(mk(1,0,0,0,1,1,32'h400,6'h1F,0,0,  0,0)); // newer one ignored
    vecs.push_back(mk(1,0,1,0,1,0,0,      6'h1F,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,1,EPC,0,0)); // fires when MEM idle
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,1,0,1,32'h800,6'h00,1,VEC,0,0)); // exc beats div_start
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0)); // no DIV started
    vecs.push_back(mk(1,0,0,1,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,1,0,0,      6'h1F,0,0,  1,0)); // mem over div
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h0F,0,0,  1,0));
    vecs.push_back(mk(1,0,0,0,0,1,32'h400,6'h00,1,VEC,1,0)); // abort at counter=2
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h0F,0,0,  1,0));
    vecs.push_back(mk(1,0,0,0,1,1,32'h400,6'h1F,0,0,  1,0)); // pending during DIV
    vecs.push_back(mk(0,1,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0)); // reset dropped both
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,      6'h00,0,0,  0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; id_stall_req = vecs[i].id; div_start_i = vecs[i].div;
      mem_stall_req = vecs[i].mem; exc_valid_i = vecs[i].exc; exc_type_i = vecs[i].typ;
      #2;
      if (vecs[i].chk)
        check_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc,
                  vecs[i].e_busy, vecs[i].e_done);
    end

    @(negedge clk);
    rst = 1'b1; exc_valid_i = 0; div_start_i = 0; mem_stall_req = 0; id_stall_req = 0;
    m_left = 0; m_bubble = 0; m_pend = 0; m_ptype = 0;

    for (int c = 0; c < 3000; c++) begin
      bit          ev, take;
      logic [31:0] tsel, e_pc;
      logic [5:0]  e_st;
      @(negedge clk);
      rst           = 1'b0;
      id_stall_req  = ($urandom_range(3) == 0);
      div_start_i   = ($urandom_range(4) == 0);
      mem_stall_req = ($urandom_range(2) == 0);
      exc_valid_i   = ($urandom_range(12) == 0);
      exc_type_i    = {$urandom_range(7) << 10} | ($urandom & 32'h3FF);
      epc_i         = $urandom;
      #2;
      ev   = exc_valid_i || m_pend;
      take = ev && !mem_stall_req;
      tsel = m_pend ? m_ptype : exc_type_i;
      e_pc = take ? (tsel[12] ? epc_i : VEC) : 32'd0;
      if (take || m_bubble)   e_st = 6'h00;
      else if (mem_stall_req) e_st = 6'h1F;
      else if (m_left > 1)    e_st = 6'h0F;
      else if (id_stall_req)  e_st = 6'h07;
      else                    e_st = 6'h00;
      check_all($sformatf("rnd%0d", c), e_st, take, e_pc, m_left > 0,
                (m_left == 1) && !take);
      if (take) begin
        m_left = 0; m_bubble = 1; m_pend = 0;
      end else begin
        if (exc_valid_i && !m_pend) begin
          m_pend = 1; m_ptype = exc_type_i;
        end
        if (m_bubble)         m_bubble = 0;
        else if (m_left > 0)  m_left--;
        else if (div_start_i) m_left = DIVC;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
